// File: rtl/bcd_disp_conv.sv
// bcd_disp_conv
//   Iterative binary-to-BCD converter for the 4-digit 7-segment driver.
//   It accepts an unsigned value over a valid/ready handshake and converts it
//   with shift-add-3 (double dabble), one input bit per clock. When the
//   conversion finishes, it registers four BCD digits and a digit-enable mask.
//   Values above 9999 are shown as four OVF_CODE digits.
//
//   Optional feature macro: LZB_EN (leading-zero blanking on sel).
//
// Parameters
//   IN_W      width of value (4..14)
//   OVF_CODE  nibble written to every digit on overflow
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear: aborts any conversion, restores reset outputs
//   in_valid  value is valid
//   in_ready  converter idle (combinational from state)
//   value     unsigned binary input
//   num       BCD digits, [15:12] thousands .. [3:0] units
//   sel       digit enable mask, bit i enables num[4i+3:4i]
//   done      one-cycle pulse when num/sel/err update
//   err       last completed conversion overflowed
module bcd_disp_conv #(
  parameter int         IN_W     = 14,
  parameter logic [3:0] OVF_CODE = 4'hE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] value,
  output logic [15:0]     num,
  output logic [3:0]      sel,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  localparam int                CNT_W    = $clog2(IN_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IN_W - 1);

`ifdef LZB_EN
  localparam logic [3:0] SEL_RST = 4'b0001;
`else
  localparam logic [3:0] SEL_RST = 4'b1111;
`endif

  logic [1:0]      state_reg;
  logic [IN_W-1:0] bin_reg;
  logic [19:0]     bcd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic            ovf_reg;
  logic [19:0]     bcd_adj;
  logic [31:0]     value_ext;
  logic [3:0]      sel_next;

  assign in_ready  = (state_reg == IDLE);
  assign value_ext = 32'(value);

  // Add-3 correction: any digit >= 5 would become >= 10 after the shift, so
  // it is pre-biased so that the carry propagates into the next digit.
  for (genvar gi = 0; gi < 5; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                              ? bcd_reg[4*gi +: 4] + 4'd3
                              : bcd_reg[4*gi +: 4];
  end

`ifdef LZB_EN
  // Enable every digit from the most significant non-zero one down to the
  // units. The units digit is always enabled so that zero shows as "0".
  logic [3:0] digit_nz;
  for (genvar gi = 0; gi < 4; gi++) begin : g_nz
    assign digit_nz[gi] = |bcd_reg[4*gi +: 4];
  end

  always_comb begin
    sel_next = 4'b0001;
    if (ovf_reg)          sel_next = 4'b1111;
    else if (digit_nz[3]) sel_next = 4'b1111;
    else if (digit_nz[2]) sel_next = 4'b0111;
    else if (digit_nz[1]) sel_next = 4'b0011;
  end
`else
  assign sel_next = 4'b1111;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      num       <= 16'h0000;
      sel       <= SEL_RST;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      num       <= 16'h0000;
      sel       <= SEL_RST;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            bin_reg   <= value;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= (value_ext > 32'd9999);
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          // The top bit of the corrected accumulator is shifted out.
          // It is always zero because the input is at most 14 bits wide.
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          if (cnt_reg == CNT_LAST) state_reg <= LOAD;
          else                     cnt_reg   <= cnt_reg + 1'b1;
        end
        LOAD: begin
          done      <= 1'b1;
          err       <= ovf_reg;
          num       <= ovf_reg ? {4{OVF_CODE}} : bcd_reg[15:0];
          sel       <= sel_next;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_disp_conv.sv
module tb_bcd_disp_conv;

  localparam int IN_W = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] value = '0;
  logic [15:0]     num;
  logic [3:0]      sel;
  logic            done;
  logic            err;

  int n_vec = 0;
  int n_bad = 0;

  // Expected display contents between completions
  logic [15:0] disp_num;
  logic [3:0]  disp_sel;
  logic        disp_err;

`ifdef LZB_EN
  localparam logic [3:0] SEL_RST = 4'b0001;
`else
  localparam logic [3:0] SEL_RST = 4'b1111;
`endif

  bcd_disp_conv #(.IN_W(IN_W), .OVF_CODE(4'hE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .value(value), .num(num), .sel(sel),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: decimal digits by plain arithmetic
  function automatic logic [15:0] ref_num(input int v);
    if (v > 9999) return 16'hEEEE;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] ref_sel(input int v);
`ifdef LZB_EN
    if (v >= 1000) return 4'b1111;
    if (v >= 100)  return 4'b0111;
    if (v >= 10)   return 4'b0011;
    return 4'b0001;
`else
    return 4'b1111;
`endif
  endfunction

  task automatic model_reset();
    disp_num = 16'h0000;
    disp_sel = SEL_RST;
    disp_err = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_num"}, 32'(num), 32'h0000);
    chk({tag, "_sel"}, 32'(sel), 32'(SEL_RST));
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Present v and stay at the negedge after the accept edge.
  task automatic start_conv(input int v);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    value = IN_W'(v);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Entered at the negedge after the accept edge k. If chain is set, nv is held
  // valid throughout the busy period and must be accepted in the done cycle.
  task automatic finish_conv(input int v, input bit chain, input int nv);
    bit hold_ok;
    bit busy_ok;
    if (chain) begin
      in_valid = 1'b1;
      value = IN_W'(nv);
    end
    hold_ok = 1'b1;
    busy_ok = (in_ready == 1'b0) && (done == 1'b0);
    for (int j = 1; j <= IN_W; j++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
      if (num !== disp_num || sel !== disp_sel || err !== disp_err) hold_ok = 1'b0;
    end
    chk("busy_ready_done_low", 32'(busy_ok), 1);
    chk("outputs_held", 32'(hold_ok), 1);
    @(negedge clk);
    disp_num = ref_num(v);
    disp_sel = (v > 9999) ? 4'b1111 : ref_sel(v);
    disp_err = (v > 9999);
    chk("done_pulse", 32'(done), 1);
    chk("num", 32'(num), 32'(disp_num));
    chk("sel", 32'(sel), 32'(disp_sel));
    chk("err", 32'(err), 32'(disp_err));
    chk("ready_after", 32'(in_ready), 1);
    $display("conv value=%0d num=%h sel=%b err=%b", v, num, sel, err);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    if (chain) begin
      chk("chain_accepted", 32'(in_ready), 0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int v;
    bit saw_done;
    model_reset();

    // Reset state
    #12;
    chk_reset_outputs("rst");
    chk("rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_rst");

    // Directed values
    start_conv(1234);  finish_conv(1234, 1'b0, 0);
    start_conv(7);     finish_conv(7, 1'b0, 0);
    start_conv(305);   finish_conv(305, 1'b0, 0);
    start_conv(0);     finish_conv(0, 1'b0, 0);
    start_conv(10000); finish_conv(10000, 1'b0, 0);
    start_conv(9999);  finish_conv(9999, 1'b0, 0);
    start_conv(16383); finish_conv(16383, 1'b0, 0);
    start_conv(50);    finish_conv(50, 1'b0, 0);

    // Back-to-back: 42 held valid while busy, accepted in the done cycle
    start_conv(5678);
    finish_conv(5678, 1'b1, 42);
    finish_conv(42, 1'b0, 0);

    // clr at shift 6: reset outputs next edge, no done pulse
    start_conv(4321);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk_reset_outputs("clr");
    chk("clr_ready", 32'(in_ready), 1);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("clr_no_done", 32'(saw_done), 0);

    // Accept coinciding with clr is dropped
    in_valid = 1'b1;
    value = IN_W'(777);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_drops_accept", 32'(in_ready), 1);
    @(negedge clk);
    chk("clr_drops_accept2", 32'(in_ready), 1);

    // Async reset mid-conversion
    start_conv(2468); finish_conv(2468, 1'b0, 0);
    start_conv(8765);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("async_rst");
    chk("async_rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (18) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("rst_no_done", 32'(saw_done), 0);
    start_conv(8765); finish_conv(8765, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) v = int'($urandom_range(16383, 0));
      else if (i % 4 == 1) v = int'($urandom_range(99, 0));
      else v = int'($urandom_range(9999, 0));
      start_conv(v);
      finish_conv(v, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit in case the flow above stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
